// File: rtl/rumo_ctrl.sv
// Heading/position controller: turns in DIRS headings at TURN_LAT cycles per step and advances one unit per AVANCA.
// Position tracking with saturation is present only when RUMO_CTRL_POS_EN is defined.
module rumo_ctrl #(
  parameter int DIRS     = 4,
  parameter int TURN_LAT = 2,
  parameter int POS_W    = 8
) (
  input  logic                    clockc2,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd,
  output logic                    cmd_ready,
  output logic [2:0]              rumo,
  output logic signed [POS_W-1:0] pos_x,
  output logic signed [POS_W-1:0] pos_y,
  output logic                    done,
  output logic                    sat
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    GIRANDO   = 2'd1,
    AVANCANDO = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GIRA_ESQ   = 2'b00,
    GIRA_DIR   = 2'b01,
    MEIA_VOLTA = 2'b10,
    AVANCA     = 2'b11
  } cmd_t;

  // DIRS is 4 or 8, so modulo-DIRS wrap is a mask on the 3-bit heading.
  localparam logic [2:0] RUMO_MASK  = 3'(DIRS - 1);
  localparam logic [2:0] HALF_TURN  = 3'(DIRS / 2);
  localparam logic [3:0] LAT_RELOAD = 4'(TURN_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic [2:0] steps_left;
  logic       dir_neg;
  logic [2:0] rumo_step;

  assign rumo_step = dir_neg ? ((rumo - 3'd1) & RUMO_MASK)
                             : ((rumo + 3'd1) & RUMO_MASK);

`ifdef RUMO_CTRL_POS_EN
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic [2:0]              rumo8;
  logic signed [1:0]       dx, dy;
  logic                    clip_x, clip_y;
  logic signed [POS_W-1:0] next_x, next_y;

  // Map a 4-heading index onto the 8-heading compass so one table serves both.
  assign rumo8 = (DIRS == 8) ? rumo : {rumo[1:0], 1'b0};

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dx = 2'sd0;
    dy = 2'sd0;
    case (rumo8)
      3'd0: begin dx =  2'sd0; dy =  2'sd1; end
      3'd1: begin dx = -2'sd1; dy =  2'sd1; end
      3'd2: begin dx = -2'sd1; dy =  2'sd0; end
      3'd3: begin dx = -2'sd1; dy = -2'sd1; end
      3'd4: begin dx =  2'sd0; dy = -2'sd1; end
      3'd5: begin dx =  2'sd1; dy = -2'sd1; end
      3'd6: begin dx =  2'sd1; dy =  2'sd0; end
      3'd7: begin dx =  2'sd1; dy =  2'sd1; end
      default: begin dx = 2'sd0; dy = 2'sd0; end
    endcase
  end

  // Unit steps can only overflow from the extreme value, so clipping is a compare.
  assign clip_x = ((dx == 2'sd1) && (pos_x == POS_MAX)) || ((dx == -2'sd1) && (pos_x == POS_MIN));
  assign clip_y = ((dy == 2'sd1) && (pos_y == POS_MAX)) || ((dy == -2'sd1) && (pos_y == POS_MIN));
  assign next_x = clip_x ? pos_x : pos_x + {{(POS_W-2){dx[1]}}, dx};
  assign next_y = clip_y ? pos_y : pos_y + {{(POS_W-2){dy[1]}}, dy};
`else
  assign pos_x = '0;
  assign pos_y = '0;
  assign sat   = 1'b0;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clockc2) begin
    if (reset) begin
      state      <= OCIOSO;
      cmd_ready  <= 1'b1;
      rumo       <= 3'd0;
      done       <= 1'b0;
      lat_cnt    <= 4'd0;
      steps_left <= 3'd0;
      dir_neg    <= 1'b0;
`ifdef RUMO_CTRL_POS_EN
      pos_x      <= '0;
      pos_y      <= '0;
      sat        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef RUMO_CTRL_POS_EN
      sat  <= 1'b0;
`endif
      case (state)
        OCIOSO: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd == AVANCA) begin
              state <= AVANCANDO;
            end else begin
              state      <= GIRANDO;
              lat_cnt    <= LAT_RELOAD;
              dir_neg    <= (cmd == GIRA_DIR);
              steps_left <= (cmd == MEIA_VOLTA) ? HALF_TURN : 3'd1;
            end
          end
        end
        GIRANDO: begin
          if (lat_cnt == 4'd0) begin
            rumo       <= rumo_step;
            lat_cnt    <= LAT_RELOAD;
            steps_left <= steps_left - 3'd1;
            if (steps_left == 3'd1) begin
              done      <= 1'b1;
              state     <= OCIOSO;
              cmd_ready <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        AVANCANDO: begin
`ifdef RUMO_CTRL_POS_EN
          pos_x <= next_x;
          pos_y <= next_y;
          sat   <= clip_x || clip_y;
`endif
          done      <= 1'b1;
          state     <= OCIOSO;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= OCIOSO;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rumo_ctrl.sv
// Directed bench for rumo_ctrl: three instances (4 headings/lat 2, 8 headings/lat 3, 4-bit position/lat 1).
// Position expectations follow RUMO_CTRL_POS_EN; without it pos and sat must read 0.
module tb_rumo_ctrl;

`ifdef RUMO_CTRL_POS_EN
  localparam bit POS_ON = 1'b1;
`else
  localparam bit POS_ON = 1'b0;
`endif

  localparam logic [1:0] C_ESQ = 2'b00, C_DIR = 2'b01, C_MEIA = 2'b10, C_AVA = 2'b11;

  logic clockc2 = 1'b0;
  logic reset   = 1'b1;
  always #5 clockc2 = ~clockc2;

  logic       cv  [3];
  logic [1:0] cm  [3];
  logic       rdy [3];
  logic       dn  [3];
  logic       st  [3];
  logic [2:0] ru  [3];
  logic signed [7:0] px0, py0, px1, py1;
  logic signed [3:0] px2, py2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] traj [0:40];

  rumo_ctrl #(.DIRS(4), .TURN_LAT(2), .POS_W(8)) u4 (
    .clockc2(clockc2), .reset(reset), .cmd_valid(cv[0]), .cmd(cm[0]), .cmd_ready(rdy[0]),
    .rumo(ru[0]), .pos_x(px0), .pos_y(py0), .done(dn[0]), .sat(st[0]));

  rumo_ctrl #(.DIRS(8), .TURN_LAT(3), .POS_W(8)) u8 (
    .clockc2(clockc2), .reset(reset), .cmd_valid(cv[1]), .cmd(cm[1]), .cmd_ready(rdy[1]),
    .rumo(ru[1]), .pos_x(px1), .pos_y(py1), .done(dn[1]), .sat(st[1]));

  rumo_ctrl #(.DIRS(4), .TURN_LAT(1), .POS_W(4)) us (
    .clockc2(clockc2), .reset(reset), .cmd_valid(cv[2]), .cmd(cm[2]), .cmd_ready(rdy[2]),
    .rumo(ru[2]), .pos_x(px2), .pos_y(py2), .done(dn[2]), .sat(st[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command to instance d, measure cycles from acceptance to done, record heading per cycle.
  task automatic run_cmd(input int d, input logic [1:0] c, input int exp_lat, input string tag);
    int n;
    @(negedge clockc2);
    cv[d] = 1'b1;
    cm[d] = c;
    check({tag, "_rdy"}, int'(rdy[d]), 1);
    @(posedge clockc2);
    #1;
    cv[d] = 1'b0;
    n = 0;
    traj[0] = ru[d];
    while (!dn[d] && n < 40) begin
      @(posedge clockc2);
      #1;
      n++;
      traj[n] = ru[d];
    end
    check({tag, "_lat"}, n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      cv[i] = 1'b0;
      cm[i] = 2'b00;
    end
    repeat (3) @(posedge clockc2);
    @(negedge clockc2);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_rdy%0d", i), int'(rdy[i]), 1);
      check($sformatf("rst_rumo%0d", i), int'(ru[i]), 0);
      check($sformatf("rst_done%0d", i), int'(dn[i]), 0);
      check($sformatf("rst_sat%0d", i), int'(st[i]), 0);
    end
    check("rst_px0", int'(px0), 0);
    check("rst_py1", int'(py1), 0);

    // 4 headings, lat 2: left turns wrap 3 -> 0, right turn wraps 0 -> 3.
    for (int i = 1; i <= 4; i++) begin
      run_cmd(0, C_ESQ, 2, $sformatf("esq4_%0d", i));
      check($sformatf("esq4_rumo%0d", i), int'(ru[0]), i % 4);
    end
    run_cmd(0, C_DIR, 2, "dir4");
    check("dir4_rumo", int'(ru[0]), 3);
    run_cmd(0, C_MEIA, 4, "meia4");
    check("meia4_rumo", int'(ru[0]), 1);

    // A request held while turning must be neither taken nor queued.
    @(negedge clockc2);
    cv[0] = 1'b1;
    cm[0] = C_ESQ;
    @(posedge clockc2);
    #1;
    cm[0] = C_AVA;
    check("busy_rdy", int'(rdy[0]), 0);
    @(posedge clockc2);
    #1;
    cv[0] = 1'b0;
    check("busy_done_early", int'(dn[0]), 0);
    @(posedge clockc2);
    #1;
    check("busy_done", int'(dn[0]), 1);
    check("busy_rumo", int'(ru[0]), 2);
    n = 0;
    repeat (4) begin
      @(posedge clockc2);
      #1;
      if (dn[0]) n++;
    end
    check("busy_extra_done", n, 0);
    check("busy_py", int'(py0), 0);
    check("busy_px", int'(px0), 0);

    // 8 headings, lat 3: half turn steps one heading every 3 cycles.
    run_cmd(1, C_MEIA, 12, "meia8");
    check("meia8_t2", int'(traj[2]), 0);
    check("meia8_t3", int'(traj[3]), 1);
    check("meia8_t5", int'(traj[5]), 1);
    check("meia8_t6", int'(traj[6]), 2);
    check("meia8_t9", int'(traj[9]), 3);
    check("meia8_t12", int'(traj[12]), 4);
    run_cmd(1, C_MEIA, 12, "meia8b");
    check("meia8b_rumo", int'(ru[1]), 0);
    run_cmd(1, C_DIR, 3, "dir8");
    check("dir8_rumo", int'(ru[1]), 7);
    for (int i = 1; i <= 3; i++) begin
      run_cmd(1, C_AVA, 1, $sformatf("ne_%0d", i));
      check($sformatf("ne_px%0d", i), int'(px1), POS_ON ? i : 0);
      check($sformatf("ne_py%0d", i), int'(py1), POS_ON ? i : 0);
      check($sformatf("ne_sat%0d", i), int'(st[1]), 0);
    end
    run_cmd(1, C_ESQ, 3, "esq8_wrap");
    check("esq8_wrap_rumo", int'(ru[1]), 0);

    // 4-bit position: north saturates at +7, sat only on clipped advances.
    for (int i = 1; i <= 9; i++) begin
      run_cmd(2, C_AVA, 1, $sformatf("satn_%0d", i));
      check($sformatf("satn_py%0d", i), int'(py2), POS_ON ? ((i < 8) ? i : 7) : 0);
      check($sformatf("satn_px%0d", i), int'(px2), 0);
      check($sformatf("satn_sat%0d", i), int'(st[2]), (POS_ON && i >= 8) ? 1 : 0);
    end
    @(posedge clockc2);
    #1;
    check("satn_sat_pulse", int'(st[2]), 0);
    check("satn_done_pulse", int'(dn[2]), 0);
    run_cmd(2, C_MEIA, 2, "meias");
    check("meias_rumo", int'(ru[2]), 2);
    run_cmd(2, C_AVA, 1, "south");
    check("south_py", int'(py2), POS_ON ? 6 : 0);
    check("south_sat", int'(st[2]), 0);

    // Reset one cycle into a half turn, with a request still asserted.
    run_cmd(1, C_ESQ, 3, "pre_rst");
    check("pre_rst_rumo", int'(ru[1]), 1);
    @(negedge clockc2);
    cv[1] = 1'b1;
    cm[1] = C_MEIA;
    @(posedge clockc2);
    #1;
    cm[1] = C_ESQ;
    reset = 1'b1;
    @(posedge clockc2);
    #1;
    check("abort_rumo", int'(ru[1]), 0);
    check("abort_rdy", int'(rdy[1]), 1);
    check("abort_done", int'(dn[1]), 0);
    check("abort_px", int'(px1), 0);
    @(negedge clockc2);
    reset = 1'b0;
    cv[1] = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clockc2);
      #1;
      if (dn[1]) n++;
    end
    check("abort_no_done", n, 0);
    check("abort_rumo_hold", int'(ru[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rumo_ctrl.md
RUMO_CTRL -- requirements
Module: rumo_ctrl

Interface
REQ-001 SHALL have parameter DIRS, default 4, number of headings; legal values 4 or 8.
REQ-002 SHALL have parameter TURN_LAT, default 2, clock cycles per single heading step; legal range 1..15.
REQ-003 SHALL have parameter POS_W, default 8, width of the signed two's-complement position counters.
REQ-004 SHALL have port clockc2  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd  input  2  command: 00 GIRA_ESQ, 01 GIRA_DIR, 10 MEIA_VOLTA, 11 AVANCA.
REQ-008 SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-009 SHALL have port rumo  output  3  current heading index; bits above clog2(DIRS) are 0.
REQ-010 SHALL have port pos_x  output  POS_W  signed X position, east positive.
REQ-011 SHALL have port pos_y  output  POS_W  signed Y position, north positive.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a command completes.
REQ-013 SHALL have port sat  output  1  one-cycle pulse, coincident with done, when an AVANCA was clipped by saturation.

Function
REQ-014 SHALL encode headings counter-clockwise from 0=Norte: DIRS=4 gives 0 N, 1 O, 2 S, 3 L; DIRS=8 gives 0 N, 1 NO, 2 O, 3 SO, 4 S, 5 SE, 6 L, 7 NE.
REQ-015 SHALL implement FSM states OCIOSO, GIRANDO, AVANCANDO; cmd_ready = 1 only in OCIOSO.
REQ-016 SHALL accept a command on a cycle where cmd_valid and cmd_ready are both 1; cmd_valid outside OCIOSO is ignored and not queued.
REQ-017 SHALL, on accepting GIRA_ESQ, GIRA_DIR or MEIA_VOLTA, enter GIRANDO with step count 1, 1 or DIRS/2 respectively.
REQ-018 SHALL, in GIRANDO, change rumo by one step every TURN_LAT cycles: +1 mod DIRS for GIRA_ESQ and MEIA_VOLTA, -1 mod DIRS for GIRA_DIR.
REQ-019 SHALL wrap rumo modulo DIRS (GIRA_ESQ from DIRS-1 gives 0; GIRA_DIR from 0 gives DIRS-1).
REQ-020 SHALL update rumo for the final step, pulse done and return to OCIOSO in the same cycle; an accepted turn has done exactly steps*TURN_LAT cycles after acceptance.
REQ-021 SHALL, on accepting AVANCA, enter AVANCANDO for one cycle, add the heading unit vector (dx,dy in {-1,0,+1}; diagonals move both axes) to pos_x/pos_y, pulse done, and return to OCIOSO; done one cycle after acceptance.
REQ-022 SHALL saturate each axis independently at +(2^(POS_W-1)-1) and -2^(POS_W-1); if either axis is clipped, pulse sat with done.
REQ-023 SHALL allow acceptance of a new command in the cycle immediately after done (back-to-back throughput).
REQ-024 SHALL hold rumo, pos_x and pos_y stable in OCIOSO.

Reset
REQ-025 SHALL, when reset is 1 at a clock edge, set state OCIOSO, rumo 0 (Norte), pos_x 0, pos_y 0, done 0, sat 0, cmd_ready 1 on the following cycle, regardless of state.
REQ-026 SHALL abort any turn or advance in progress on reset, with no done pulse and no partial heading retained; reset takes priority over cmd_valid.

Configuration
REQ-027 SHALL compile in position tracking (pos_x/pos_y counters, saturation, sat) only when macro RUMO_CTRL_POS_EN is defined.
REQ-028 SHALL, without RUMO_CTRL_POS_EN, drive pos_x, pos_y and sat constant 0 and still complete AVANCA with done one cycle after acceptance.

Verification
REQ-029 SHALL test DIRS=4, TURN_LAT=2: reset, GIRA_ESQ x4 -> rumo 1,2,3,0, each done 2 cycles after acceptance.
REQ-030 SHALL test DIRS=8, TURN_LAT=3: MEIA_VOLTA from 0 -> rumo steps 1,2,3,4, done 12 cycles after acceptance; GIRA_DIR from 0 -> rumo 7.
REQ-031 SHALL test DIRS=8, POS_EN on: GIRA_DIR to NE then AVANCA x3 -> pos_x 3, pos_y 3, no sat.
REQ-032 SHALL test POS_W=4, POS_EN on: heading N, AVANCA x9 -> pos_y saturates at 7, sat pulses on 8th and 9th done only.
REQ-033 SHALL test reset at cycle 1 of a MEIA_VOLTA -> next cycle rumo 0, cmd_ready 1, no done; cmd_valid during GIRANDO ignored.
